// File: rtl/seq_div_8x4_if.sv
// seq_div_8x4_if: start/busy/done handshake and operand/result bus for the sequential divider.
interface seq_div_8x4_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quo;
    logic [VW-1:0] rem;
    logic          dbz;
    modport master (output start, dividend, divisor, input busy, done, quo, rem, dbz);
    modport slave  (input start, dividend, divisor, output busy, done, quo, rem, dbz);
endinterface

// File: rtl/seq_div_8x4.sv
// seq_div_8x4: restoring divider, one quotient bit per clock, divide-by-zero yields all-ones quotient.
module seq_div_8x4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic clk,
    input  logic rst,
    seq_div_8x4_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;
    localparam int CW = $clog2(DW + 1);
    state_t        state;
    logic [DW-1:0] q;
    logic [VW-1:0] d;
    logic [VW-1:0] r;
    logic [CW-1:0] cnt;
    logic [VW:0]   rs;
    logic          borrow;
    logic [VW-1:0] r_nx;
    logic [DW-1:0] q_nx;
    // Restoring keeps r < d, so the stored remainder fits VW bits; only the shifted value needs VW+1.
    always_comb begin
        rs     = {r, q[DW-1]};
        borrow = rs < {1'b0, d};
        r_nx   = borrow ? rs[VW-1:0] : VW'(rs - {1'b0, d});
        q_nx   = {q[DW-2:0], ~borrow};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            q        <= '0;
            d        <= '0;
            r        <= '0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.quo  <= '0;
            bus.rem  <= '0;
            bus.dbz  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bus.busy <= 1'b1;
                    if (bus.divisor != '0) begin
                        q     <= bus.dividend;
                        d     <= bus.divisor;
                        r     <= '0;
                        cnt   <= CW'(DW);
                        state <= RUN;
                    end else begin
                        state <= ZERO;
                    end
                end
                RUN: begin
                    q   <= q_nx;
                    r   <= r_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bus.quo  <= q_nx;
                        bus.rem  <= r_nx;
                        bus.dbz  <= 1'b0;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ZERO: begin
                    bus.quo  <= '1;
                    bus.rem  <= '0;
                    bus.dbz  <= 1'b1;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div_8x4.sv
// tb_seq_div_8x4: scoreboard bench; expected results queued at acceptance, checked on each done pulse.
module tb_seq_div_8x4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    seq_div_8x4_if bus ();
    seq_div_8x4 dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         e;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int busy_end = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                x = sb.pop_front();
                chk("quo", 32'(bus.quo), 32'(x.q));
                chk("rem", 32'(bus.rem), 32'(x.r));
                chk("dbz", 32'(bus.dbz), 32'(x.z));
                chk("latency", cyc - 1, x.e);
            end
        end
    end

    // Edge index e = cyc-1 at the negedge after it; the DUT is idle at e once the last done edge is behind it.
    task automatic pulse(input logic [7:0] a, input logic [3:0] b, output bit acc);
        int e;
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor = 4'($urandom);
        e = cyc - 1;
        acc = e > busy_end;
        if (acc) begin
            busy_end = e + (b == 0 ? 1 : 8);
            sb.push_back('{b == 0 ? 8'hFF : 8'(a / b), b == 0 ? 4'h0 : 4'(a % b), b == 0, busy_end});
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) pulse(a, b, acc);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        busy_end = -1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_quo"}, 32'(bus.quo), 0);
        chk({tag, "_rem"}, 32'(bus.rem), 0);
        chk({tag, "_dbz"}, 32'(bus.dbz), 0);
    endtask

    logic [7:0] ba[5] = '{8'd255, 8'd5, 8'd255, 8'd0, 8'd200};
    logic [3:0] bb[5] = '{4'd1, 4'd9, 4'd15, 4'd3, 4'd7};

    initial begin
        bit acc;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        @(negedge clk);
        do_reset();
        chk_zero("reset");
        issue(8'd200, 4'd7);
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", 32'(bus.busy), 1);
            @(negedge clk);
        end
        chk("busy_after", 32'(bus.busy), 0);
        drain();
        for (int i = 0; i < 5; i++) issue(ba[i], bb[i]);
        drain();
        issue(8'd77, 4'd0);
        issue(8'd77, 4'd7);
        drain();
        issue(8'd100, 4'd3);
        repeat (3) @(negedge clk);
        pulse(8'd9, 4'd2, acc);
        issue(8'd9, 4'd2);
        drain();
        issue(8'd200, 4'd7);
        repeat (3) @(negedge clk);
        do_reset();
        chk_zero("midrst");
        repeat (12) @(negedge clk);
        issue(8'd50, 4'd6);
        drain();
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++) issue(8'(a), 4'(b));
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
